// File: rtl/box_track_ctrl.sv
// Per-frame box qualifier: SEARCH/CONFIRM/TRACK/COAST acquisition, edge smoothing
// and detector ROI steering (full frame while searching, box plus margin while tracking).
module box_track_ctrl #(
  parameter int H_ACT     = 640,
  parameter int V_ACT     = 480,
  parameter int CONFIRM_N = 3,
  parameter int LOST_N    = 8,
  parameter int MAX_JUMP  = 32,
  parameter int MARGIN    = 16,
  parameter int DATA_W    = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              box_stb,
  input  logic              force_search,
  input  logic [DATA_W-1:0] x_min_i,
  input  logic [DATA_W-1:0] x_max_i,
  input  logic [DATA_W-1:0] y_min_i,
  input  logic [DATA_W-1:0] y_max_i,
  output logic              trk_valid,
  output logic [1:0]        state_o,
  output logic [DATA_W-1:0] x_min_o,
  output logic [DATA_W-1:0] x_max_o,
  output logic [DATA_W-1:0] y_min_o,
  output logic [DATA_W-1:0] y_max_o,
  output logic [DATA_W-1:0] roi_x_min,
  output logic [DATA_W-1:0] roi_x_max,
  output logic [DATA_W-1:0] roi_y_min,
  output logic [DATA_W-1:0] roi_y_max
);

  localparam logic [1:0] S_SEARCH  = 2'd0;
  localparam logic [1:0] S_CONFIRM = 2'd1;
  localparam logic [1:0] S_TRACK   = 2'd2;
  localparam logic [1:0] S_COAST   = 2'd3;

  localparam logic [3:0]              CONFIRM_CNT = 4'(CONFIRM_N);
  localparam logic [3:0]              LOST_CNT    = 4'(LOST_N);
  localparam logic signed [DATA_W:0]  JUMP_S      = (DATA_W+1)'(MAX_JUMP);
  localparam logic signed [DATA_W:0]  MARGIN_S    = (DATA_W+1)'(MARGIN);
  localparam logic [DATA_W-1:0]       H_LAST      = DATA_W'(H_ACT - 1);
  localparam logic [DATA_W-1:0]       V_LAST      = DATA_W'(V_ACT - 1);

  // |a-b| <= MAX_JUMP on a widened signed difference so nothing wraps
  function automatic logic edge_near(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic signed [DATA_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) d = -d;
    return d <= JUMP_S;
  endfunction

  function automatic logic [DATA_W-1:0] edge_avg(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b} + (DATA_W+1)'(1);
    return s[DATA_W:1];
  endfunction

  function automatic logic [DATA_W-1:0] roi_lo(input logic [DATA_W-1:0] v);
    logic signed [DATA_W:0] d;
    d = $signed({1'b0, v}) - MARGIN_S;
    return (d < 0) ? '0 : d[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] roi_hi(input logic [DATA_W-1:0] v, input logic [DATA_W-1:0] lim);
    logic [DATA_W:0] s;
    s = {1'b0, v} + MARGIN_S;
    return (s > {1'b0, lim}) ? lim : s[DATA_W-1:0];
  endfunction

  // Stage p0: capture the frame result and the abort request
  logic                         vld_p0, frc_p0;
  logic [3:0][DATA_W-1:0]       in_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      frc_p0 <= 1'b0;
    end else begin
      vld_p0 <= box_stb;
      frc_p0 <= force_search;
    end
  end

  always_ff @(posedge clk) begin
    in_p0[0] <= x_min_i;
    in_p0[1] <= x_max_i;
    in_p0[2] <= y_min_i;
    in_p0[3] <= y_max_i;
  end

  // Stage p1: qualification state machine and tracked box
  logic [1:0]             state_p1, state_n;
  logic [3:0]             hit_p1, hit_n, miss_p1, miss_n, miss_inc;
  logic [3:0][DATA_W-1:0] box_p1, box_n, avg_box;
  logic                   found, consistent;

  always_comb begin
    found      = vld_p0 && (in_p0[1] > in_p0[0]) && (in_p0[3] > in_p0[2]);
    consistent = 1'b1;
    avg_box    = '0;
    for (int i = 0; i < 4; i++) begin
      consistent = consistent && edge_near(in_p0[i], box_p1[i]);
      avg_box[i] = edge_avg(box_p1[i], in_p0[i]);
    end
    miss_inc = ((state_p1 == S_TRACK) ? 4'd0 : miss_p1) + 4'd1;
  end

  always_comb begin
    state_n = state_p1;
    hit_n   = hit_p1;
    miss_n  = miss_p1;
    box_n   = box_p1;
    if (frc_p0) begin
      state_n = S_SEARCH;
      hit_n   = '0;
      miss_n  = '0;
      box_n   = '0;
    end else if (vld_p0) begin
      case (state_p1)
        S_SEARCH: begin
          if (found) begin
            box_n = in_p0;
            hit_n = 4'd1;
            if (CONFIRM_CNT == 4'd1) begin
              state_n = S_TRACK;
              miss_n  = '0;
            end else begin
              state_n = S_CONFIRM;
            end
          end
        end
        S_CONFIRM: begin
          if (found && consistent) begin
            box_n = in_p0;
            hit_n = hit_p1 + 4'd1;
            if (hit_p1 + 4'd1 == CONFIRM_CNT) begin
              state_n = S_TRACK;
              miss_n  = '0;
            end
          end else if (found) begin
            box_n = in_p0;
            hit_n = 4'd1;
          end else begin
            state_n = S_SEARCH;
            hit_n   = '0;
          end
        end
        default: begin
          if (found && consistent) begin
            state_n = S_TRACK;
            box_n   = avg_box;
            miss_n  = '0;
          end else if (miss_inc == LOST_CNT) begin
            state_n = S_SEARCH;
            box_n   = '0;
            hit_n   = '0;
            miss_n  = '0;
          end else begin
            state_n = S_COAST;
            miss_n  = miss_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= S_SEARCH;
      hit_p1   <= '0;
      miss_p1  <= '0;
      box_p1   <= '0;
    end else begin
      state_p1 <= state_n;
      hit_p1   <= hit_n;
      miss_p1  <= miss_n;
      box_p1   <= box_n;
    end
  end

  assign trk_valid = (state_p1 == S_TRACK) || (state_p1 == S_COAST);
  assign state_o   = state_p1;
  assign x_min_o   = trk_valid ? box_p1[0] : '0;
  assign x_max_o   = trk_valid ? box_p1[1] : '0;
  assign y_min_o   = trk_valid ? box_p1[2] : '0;
  assign y_max_o   = trk_valid ? box_p1[3] : '0;

  // Stage p2: detector search window from the updated state and box
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      roi_x_min <= '0;
      roi_x_max <= H_LAST;
      roi_y_min <= '0;
      roi_y_max <= V_LAST;
    end else if (trk_valid) begin
      roi_x_min <= roi_lo(box_p1[0]);
      roi_x_max <= roi_hi(box_p1[1], H_LAST);
      roi_y_min <= roi_lo(box_p1[2]);
      roi_y_max <= roi_hi(box_p1[3], V_LAST);
    end else begin
      roi_x_min <= '0;
      roi_x_max <= H_LAST;
      roi_y_min <= '0;
      roi_y_max <= V_LAST;
    end
  end

endmodule

// File: tb/tb_box_track_ctrl.sv
// Directed bench for box_track_ctrl: acquisition, smoothing, coasting, reload,
// ROI clamping, forced search, back-to-back strobes and asynchronous reset.
module tb_box_track_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        box_stb = 1'b0;
  logic        force_search = 1'b0;
  logic [11:0] x_min_i = '0, x_max_i = '0, y_min_i = '0, y_max_i = '0;
  logic        trk_valid;
  logic [1:0]  state_o;
  logic [11:0] x_min_o, x_max_o, y_min_o, y_max_o;
  logic [11:0] roi_x_min, roi_x_max, roi_y_min, roi_y_max;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  box_track_ctrl dut (
    .clk(clk), .rst_n(rst_n), .box_stb(box_stb), .force_search(force_search),
    .x_min_i(x_min_i), .x_max_i(x_max_i), .y_min_i(y_min_i), .y_max_i(y_max_i),
    .trk_valid(trk_valid), .state_o(state_o),
    .x_min_o(x_min_o), .x_max_o(x_max_o), .y_min_o(y_min_o), .y_max_o(y_max_o),
    .roi_x_min(roi_x_min), .roi_x_max(roi_x_max), .roi_y_min(roi_y_min), .roi_y_max(roi_y_max)
  );

  // One strobe, returning on the negedge after the state update edge.
  task automatic frame(input int a, input int b, input int c, input int d);
    @(negedge clk);
    x_min_i = 12'(a); x_max_i = 12'(b); y_min_i = 12'(c); y_max_i = 12'(d);
    box_stb = 1'b1;
    @(negedge clk);
    box_stb = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (state_o !== 2'd0 || trk_valid !== 1'b0) begin errors++;
      $display("FAIL reset_state: state=%0d trk=%0b want 0/0", state_o, trk_valid); end
    checks++; if ({x_min_o, x_max_o, y_min_o, y_max_o} !== 48'd0) begin errors++;
      $display("FAIL reset_box: %0d %0d %0d %0d want 0", x_min_o, x_max_o, y_min_o, y_max_o); end
    checks++; if ({roi_x_min, roi_x_max, roi_y_min, roi_y_max} !== {12'd0, 12'd639, 12'd0, 12'd479}) begin errors++;
      $display("FAIL reset_roi: %0d %0d %0d %0d want 0 639 0 479", roi_x_min, roi_x_max, roi_y_min, roi_y_max); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_acquire;
    logic [1:0] want [3] = '{2'd1, 2'd1, 2'd2};
    for (int i = 0; i < 3; i++) begin
      frame(100, 200, 50, 150);
      checks++; if (state_o !== want[i]) begin errors++;
        $display("FAIL acquire_state%0d: %0d want %0d", i, state_o, want[i]); end
    end
    checks++; if (trk_valid !== 1'b1 || {x_min_o, x_max_o, y_min_o, y_max_o} !== {12'd100, 12'd200, 12'd50, 12'd150}) begin errors++;
      $display("FAIL acquire_box: trk=%0b %0d %0d %0d %0d want 1 100 200 50 150", trk_valid, x_min_o, x_max_o, y_min_o, y_max_o); end
    checks++; if (roi_x_min !== 12'd0 || roi_x_max !== 12'd639) begin errors++;
      $display("FAIL acquire_roi_latency: %0d %0d want still 0 639", roi_x_min, roi_x_max); end
    @(negedge clk);
    checks++; if ({roi_x_min, roi_x_max, roi_y_min, roi_y_max} !== {12'd84, 12'd216, 12'd34, 12'd166}) begin errors++;
      $display("FAIL acquire_roi: %0d %0d %0d %0d want 84 216 34 166", roi_x_min, roi_x_max, roi_y_min, roi_y_max); end
  endtask

  task automatic test_smooth;
    frame(110, 210, 60, 160);
    checks++; if (state_o !== 2'd2 || {x_min_o, x_max_o, y_min_o, y_max_o} !== {12'd105, 12'd205, 12'd55, 12'd155}) begin errors++;
      $display("FAIL smooth: st=%0d %0d %0d %0d %0d want 2 105 205 55 155", state_o, x_min_o, x_max_o, y_min_o, y_max_o); end
  endtask

  task automatic test_coast_lost;
    frame(0, 0, 0, 0);
    checks++; if (state_o !== 2'd3 || trk_valid !== 1'b1 || {x_min_o, x_max_o, y_min_o, y_max_o} !== {12'd105, 12'd205, 12'd55, 12'd155}) begin errors++;
      $display("FAIL coast_enter: st=%0d trk=%0b %0d %0d %0d %0d want 3 1 105 205 55 155", state_o, trk_valid, x_min_o, x_max_o, y_min_o, y_max_o); end
    repeat (4) @(negedge clk);
    checks++; if (state_o !== 2'd3) begin errors++;
      $display("FAIL coast_idle: %0d want 3", state_o); end
    for (int i = 2; i <= 7; i++) frame(0, 0, 0, 0);
    checks++; if (state_o !== 2'd3) begin errors++;
      $display("FAIL coast_miss7: %0d want 3", state_o); end
    frame(0, 0, 0, 0);
    checks++; if (state_o !== 2'd0 || trk_valid !== 1'b0 || {x_min_o, x_max_o, y_min_o, y_max_o} !== 48'd0) begin errors++;
      $display("FAIL lost: st=%0d trk=%0b x_min=%0d want 0 0 0", state_o, trk_valid, x_min_o); end
    @(negedge clk);
    checks++; if ({roi_x_min, roi_x_max, roi_y_min, roi_y_max} !== {12'd0, 12'd639, 12'd0, 12'd479}) begin errors++;
      $display("FAIL lost_roi: %0d %0d %0d %0d want 0 639 0 479", roi_x_min, roi_x_max, roi_y_min, roi_y_max); end
  endtask

  task automatic test_reload;
    frame(100, 200, 50, 150);
    frame(100, 200, 50, 150);
    frame(200, 300, 50, 150);
    checks++; if (state_o !== 2'd1) begin errors++;
      $display("FAIL reload_stay: %0d want 1", state_o); end
    frame(200, 300, 50, 150);
    checks++; if (state_o !== 2'd1) begin errors++;
      $display("FAIL reload_hit2: %0d want 1", state_o); end
    frame(200, 300, 50, 150);
    checks++; if (state_o !== 2'd2 || {x_min_o, x_max_o, y_min_o, y_max_o} !== {12'd200, 12'd300, 12'd50, 12'd150}) begin errors++;
      $display("FAIL reload_track: st=%0d %0d %0d %0d %0d want 2 200 300 50 150", state_o, x_min_o, x_max_o, y_min_o, y_max_o); end
  endtask

  task automatic test_clamp_force;
    @(negedge clk);
    force_search = 1'b1;
    @(negedge clk);
    force_search = 1'b0;
    @(negedge clk);
    checks++; if (state_o !== 2'd0 || x_min_o !== 12'd0) begin errors++;
      $display("FAIL force_alone: st=%0d x_min=%0d want 0 0", state_o, x_min_o); end
    repeat (3) frame(5, 630, 5, 470);
    @(negedge clk);
    checks++; if (state_o !== 2'd2 || {roi_x_min, roi_x_max, roi_y_min, roi_y_max} !== {12'd0, 12'd639, 12'd0, 12'd479}) begin errors++;
      $display("FAIL clamp_roi: st=%0d %0d %0d %0d %0d want 2 0 639 0 479", state_o, roi_x_min, roi_x_max, roi_y_min, roi_y_max); end
    @(negedge clk);
    x_min_i = 12'd6; x_max_i = 12'd631; y_min_i = 12'd6; y_max_i = 12'd471;
    box_stb = 1'b1; force_search = 1'b1;
    @(negedge clk);
    box_stb = 1'b0; force_search = 1'b0;
    @(negedge clk);
    checks++; if (state_o !== 2'd0 || trk_valid !== 1'b0 || x_max_o !== 12'd0) begin errors++;
      $display("FAIL force_stb: st=%0d trk=%0b x_max=%0d want 0 0 0", state_o, trk_valid, x_max_o); end
    repeat (2) @(negedge clk);
    checks++; if (state_o !== 2'd0) begin errors++;
      $display("FAIL force_drop: %0d want 0", state_o); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    x_min_i = 12'd300; x_max_i = 12'd400; y_min_i = 12'd200; y_max_i = 12'd300;
    box_stb = 1'b1;
    repeat (3) @(negedge clk);
    box_stb = 1'b0;
    @(negedge clk);
    checks++; if (state_o !== 2'd2 || x_max_o !== 12'd400) begin errors++;
      $display("FAIL b2b_state: st=%0d x_max=%0d want 2 400", state_o, x_max_o); end
    @(negedge clk);
    checks++; if ({roi_x_min, roi_x_max, roi_y_min, roi_y_max} !== {12'd284, 12'd416, 12'd184, 12'd316}) begin errors++;
      $display("FAIL b2b_roi: %0d %0d %0d %0d want 284 416 184 316", roi_x_min, roi_x_max, roi_y_min, roi_y_max); end
  endtask

  task automatic test_async_reset;
    logic [1:0] want [3] = '{2'd1, 2'd1, 2'd2};
    frame(0, 0, 0, 0);
    @(negedge clk);
    checks++; if (state_o !== 2'd3) begin errors++;
      $display("FAIL pre_reset_coast: %0d want 3", state_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (state_o !== 2'd0 || trk_valid !== 1'b0 || {x_min_o, x_max_o, y_min_o, y_max_o} !== 48'd0) begin errors++;
      $display("FAIL async_reset_out: st=%0d trk=%0b x_min=%0d want 0 0 0", state_o, trk_valid, x_min_o); end
    checks++; if ({roi_x_min, roi_x_max, roi_y_min, roi_y_max} !== {12'd0, 12'd639, 12'd0, 12'd479}) begin errors++;
      $display("FAIL async_reset_roi: %0d %0d %0d %0d want 0 639 0 479", roi_x_min, roi_x_max, roi_y_min, roi_y_max); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      frame(300, 400, 200, 300);
      checks++; if (state_o !== want[i]) begin errors++;
        $display("FAIL reacquire%0d: %0d want %0d", i, state_o, want[i]); end
    end
  endtask

  initial begin
    test_reset;
    test_acquire;
    test_smooth;
    test_coast_lost;
    test_reload;
    test_clamp_force;
    test_back_to_back;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
